ir_nec_rx: RTL and testbench

- Parametrised NEC infrared frame receiver: successor to the fixed-timing lab decoder.
- Samples the raw IRDA_RX line and measures pulse widths with a prescaled time base derived from any clock frequency.
- Validates leader, 32 data bits and stop burst; optional repeat-frame recognition.
- Presents address/key with a one-cycle valid strobe to downstream display/control logic; reports malformed frames with an error code.

---
 rtl/ir_nec_rx_if.sv | 14 +
 rtl/ir_nec_rx.sv | 228 ++++++++++++++++++++++
 tb/tb_ir_nec_rx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ir_nec_rx_if.sv
// Decoded-frame output bundle of the NEC IR receiver (master = receiver, slave = consumer).
interface ir_nec_rx_if;
  logic [31:0] data;
  logic [15:0] addr;
  logic [7:0]  key;
  logic        data_valid;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;
  logic        repeat_pulse;

  modport master (output data, addr, key, data_valid, err, err_code, busy, repeat_pulse);
  modport slave  (input  data, addr, key, data_valid, err, err_code, busy, repeat_pulse);
endinterface

// File: rtl/ir_nec_rx.sv
// Parametrised NEC IR frame receiver: sync + glitch filter, 10 us width counter, frame FSM.
// Define IR_NEC_REPEAT_EN to recognise repeat frames (repeat_pulse is tied 0 otherwise).
module ir_nec_rx #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned GLITCH_CYC = 8,
  parameter int unsigned TOL_PCT    = 25,
  parameter bit          CHECK_INV  = 1'b1
) (
  input  logic        CLK_50M,
  input  logic        rst,
  input  logic        IRDA_RX,
  ir_nec_rx_if.master frame_o
);

  localparam int unsigned PRESC = (CLK_HZ / 100_000 == 0) ? 1 : CLK_HZ / 100_000;
  localparam int unsigned PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned GW    = $clog2(GLITCH_CYC) + 1;

  function automatic logic [10:0] wlo(input int unsigned n);
    return 11'(n * (100 - TOL_PCT) / 100);
  endfunction

  function automatic logic [10:0] whi(input int unsigned n);
    return 11'(n * (100 + TOL_PCT) / 100);
  endfunction

  function automatic logic inw(input logic [10:0] w, input int unsigned n);
    return (w >= wlo(n)) && (w <= whi(n));
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_LO, S_LEAD_HI, S_BIT_LO, S_BIT_HI, S_STOP, S_REP_STOP, S_ERROR
  } state_e;

  logic          sync1_q, sync2_q, filt_q;
  logic [GW-1:0] gcnt_q;
  logic [PW-1:0] pre_q;
  logic [10:0]   cnt_q;
  logic          filt_chg, fall, rise, tick;

  state_e        state_q, state_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   sh_q, sh_d, data_q, data_d;
  logic          dv_q, dv_d, err_q, err_d;
  logic [1:0]    code_q, code_d, ecode;
  logic          go_err;

  assign filt_chg = (sync2_q != filt_q) && (gcnt_q == GW'(GLITCH_CYC - 1));
  assign fall     = filt_chg & filt_q;
  assign rise     = filt_chg & ~filt_q;
  assign tick     = (pre_q == PW'(PRESC - 1));

  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      gcnt_q  <= '0;
    end else begin
      sync1_q <= IRDA_RX;
      sync2_q <= sync1_q;
      if (sync2_q == filt_q) begin
        gcnt_q <= '0;
      end else if (filt_chg) begin
        filt_q <= sync2_q;
        gcnt_q <= '0;
      end else begin
        gcnt_q <= gcnt_q + 1'b1;
      end
    end
  end

  // Prescaler restarts on each filtered edge so every width is measured from a tick boundary.
  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (filt_chg) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick && cnt_q != 11'd2047) cnt_q <= cnt_q + 11'd1;
    end
  end

`ifdef IR_NEC_REPEAT_EN
  localparam logic [13:0] REP_MAX = 14'd11000;
  logic [13:0] rep_cnt_q;
  logic        rep_seen_q, rep_ok, rep_q, rep_d;

  assign rep_ok = rep_seen_q && (rep_cnt_q <= REP_MAX);

  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      rep_cnt_q  <= '0;
      rep_seen_q <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      rep_q <= rep_d;
      if (dv_d || rep_d) begin
        rep_cnt_q  <= '0;
        rep_seen_q <= 1'b1;
      end else if (tick && rep_cnt_q <= REP_MAX) begin
        rep_cnt_q <= rep_cnt_q + 14'd1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    go_err  = 1'b0;
    ecode   = 2'd1;
`ifdef IR_NEC_REPEAT_EN
    rep_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (fall) state_d = S_LEAD_LO;
      S_LEAD_LO: begin
        if (rise) state_d = inw(cnt_q, 900) ? S_LEAD_HI : S_IDLE;
        else if (cnt_q > whi(900)) go_err = 1'b1;
      end
      S_LEAD_HI: begin
        if (fall) begin
          if (inw(cnt_q, 450)) begin
            state_d = S_BIT_LO;
            bit_d   = '0;
          end
`ifdef IR_NEC_REPEAT_EN
          else if (inw(cnt_q, 225)) state_d = S_REP_STOP;
`endif
          else go_err = 1'b1;
        end else if (cnt_q > whi(450)) go_err = 1'b1;
      end
      S_BIT_LO: begin
        if (rise) begin
          if (inw(cnt_q, 56)) state_d = S_BIT_HI;
          else go_err = 1'b1;
        end else if (cnt_q > whi(56)) go_err = 1'b1;
      end
      S_BIT_HI: begin
        if (fall) begin
          if (inw(cnt_q, 56) || inw(cnt_q, 169)) begin
            sh_d    = {~inw(cnt_q, 56), sh_q[31:1]};
            bit_d   = bit_q + 5'd1;
            state_d = (bit_q == 5'd31) ? S_STOP : S_BIT_LO;
          end else go_err = 1'b1;
        end else if (cnt_q > whi(169)) go_err = 1'b1;
      end
      S_STOP: begin
        if (rise) begin
          if (!inw(cnt_q, 56)) begin
            go_err = 1'b1;
            ecode  = 2'd3;
          end else if (CHECK_INV && (sh_q[31:24] != ~sh_q[23:16])) begin
            go_err = 1'b1;
            ecode  = 2'd2;
          end else begin
            data_d  = sh_q;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (cnt_q > whi(56)) go_err = 1'b1;
      end
`ifdef IR_NEC_REPEAT_EN
      S_REP_STOP: begin
        if (rise) begin
          if (inw(cnt_q, 56)) begin
            rep_d   = rep_ok;
            state_d = S_IDLE;
          end else begin
            go_err = 1'b1;
            ecode  = 2'd3;
          end
        end else if (cnt_q > whi(56)) go_err = 1'b1;
      end
`endif
      S_ERROR: if (filt_q && cnt_q >= 11'd1000) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (go_err) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
      code_d  = ecode;
    end
  end

  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign frame_o.data       = data_q;
  assign frame_o.addr       = data_q[15:0];
  assign frame_o.key        = data_q[23:16];
  assign frame_o.data_valid = dv_q;
  assign frame_o.err        = err_q;
  assign frame_o.err_code   = code_q;
  assign frame_o.busy       = (state_q != S_IDLE);
`ifdef IR_NEC_REPEAT_EN
  assign frame_o.repeat_pulse = rep_q;
`else
  assign frame_o.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_ir_nec_rx.sv
// Directed bench for ir_nec_rx: frame-level event scoreboard plus literal spot checks.
// Runs with a 1-cycle tick (CLK_HZ = 100 kHz) so widths in cycles equal widths in ticks.
module tb_ir_nec_rx;

  localparam logic [1:0] EV_DV  = 2'd0;
  localparam logic [1:0] EV_ERR = 2'd1;
  localparam logic [1:0] EV_REP = 2'd2;
  localparam logic [31:0] GOOD  = 32'hA9563412;
  localparam logic [31:0] BADINV = 32'hAA563412;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ir  = 1'b1;

  int checks   = 0;
  int failures = 0;

  ev_t         exp_q[$];
  logic [31:0] model_data = '0;
  logic [1:0]  model_code = '0;
  logic [31:0] prev_data  = '0;
  logic [1:0]  prev_code  = '0;

  always #5 clk = ~clk;

  ir_nec_rx_if dut_if ();

  ir_nec_rx #(
    .CLK_HZ    (100_000),
    .GLITCH_CYC(8),
    .TOL_PCT   (25),
    .CHECK_INV (1'b1)
  ) dut (
    .CLK_50M(clk),
    .rst    (rst),
    .IRDA_RX(ir),
    .frame_o(dut_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic lvl, input int n);
    ir = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    hold(1'b0, 56);
    hold(1'b1, b ? 169 : 56);
  endtask

  // Full frame; gbit >= 0 injects a 3-cycle low glitch into that bit's high phase.
  task automatic send_frame(input logic [31:0] w, input int gbit);
    if (w[31:24] != ~w[23:16]) expect_ev(EV_ERR, 32'd2);
    else expect_ev(EV_DV, w);
    hold(1'b0, 900);
    hold(1'b1, 450);
    chk("busy_in_frame", dut_if.busy, 1'b1);
    for (int i = 0; i < 32; i++) begin
      if (i == gbit) begin
        hold(1'b0, 56);
        hold(1'b1, 40);
        hold(1'b0, 3);
        hold(1'b1, (w[i] ? 169 : 56) - 43);
      end else begin
        send_bit(w[i]);
      end
    end
    hold(1'b0, 56);
    hold(1'b1, 1200);
    chk("pending_events", exp_q.size(), 0);
    chk("busy_after_frame", dut_if.busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dut_if.data_valid || dut_if.err || dut_if.repeat_pulse) begin
        logic [1:0] k;
        ev_t e;
        k = dut_if.data_valid ? EV_DV : (dut_if.err ? EV_ERR : EV_REP);
        chk("dv_err_exclusive", {31'd0, dut_if.data_valid & dut_if.err}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, k}, 32'd3);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {30'd0, k}, {30'd0, e.kind});
          if (k == e.kind && k == EV_DV) begin
            chk("dv_data", dut_if.data, e.val);
            model_data = e.val;
          end else if (k == e.kind && k == EV_ERR) begin
            chk("err_code_event", {30'd0, dut_if.err_code}, e.val);
            model_code = e.val[1:0];
          end
        end
      end
      if (dut_if.data !== prev_data || dut_if.data_valid) begin
        chk("data_hold", dut_if.data, model_data);
        chk("addr_hold", {16'd0, dut_if.addr}, {16'd0, model_data[15:0]});
        chk("key_hold", {24'd0, dut_if.key}, {24'd0, model_data[23:16]});
      end
      if (dut_if.err_code !== prev_code) begin
        chk("err_code_hold", {30'd0, dut_if.err_code}, {30'd0, model_code});
      end
      prev_data = dut_if.data;
      prev_code = dut_if.err_code;
    end
  end

  initial begin
    rst = 1'b1;
    ir  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", dut_if.data, 32'd0);
    chk("rst_dv", dut_if.data_valid, 1'b0);
    chk("rst_err", dut_if.err, 1'b0);
    chk("rst_code", dut_if.err_code, 2'd0);
    chk("rst_busy", dut_if.busy, 1'b0);
    chk("rst_rep", dut_if.repeat_pulse, 1'b0);
    rst = 1'b0;
    hold(1'b1, 50);

    send_frame(GOOD, -1);
    chk("lit_data", dut_if.data, 32'hA9563412);
    chk("lit_addr", dut_if.addr, 16'h3412);
    chk("lit_key", dut_if.key, 8'h56);

    send_frame(BADINV, -1);
    chk("lit_code_inv", dut_if.err_code, 2'd2);
    chk("lit_data_kept", dut_if.data, 32'hA9563412);

    hold(1'b0, 50);
    chk("busy_noise", dut_if.busy, 1'b1);
    hold(1'b0, 50);
    hold(1'b1, 1200);
    chk("busy_after_noise", dut_if.busy, 1'b0);
    chk("pending_noise", exp_q.size(), 0);

    send_frame(GOOD, 4);
    chk("lit_data_glitch", dut_if.data, 32'hA9563412);

    expect_ev(EV_ERR, 32'd1);
    hold(1'b0, 900);
    hold(1'b1, 450);
    for (int i = 0; i < 16; i++) send_bit(GOOD[i]);
    hold(1'b1, 2000);
    chk("pending_trunc", exp_q.size(), 0);
    chk("lit_code_trunc", dut_if.err_code, 2'd1);
    chk("busy_after_trunc", dut_if.busy, 1'b0);

    send_frame(GOOD, -1);
    hold(1'b1, 4000);
`ifdef IR_NEC_REPEAT_EN
    expect_ev(EV_REP, 32'd0);
`else
    expect_ev(EV_ERR, 32'd1);
`endif
    hold(1'b0, 900);
    hold(1'b1, 225);
    hold(1'b0, 56);
    hold(1'b1, 1200);
    chk("pending_repeat", exp_q.size(), 0);
    chk("lit_data_repeat", dut_if.data, 32'hA9563412);
    chk("busy_after_repeat", dut_if.busy, 1'b0);

    hold(1'b0, 900);
    hold(1'b1, 450);
    for (int i = 0; i < 8; i++) send_bit(GOOD[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_data", dut_if.data, 32'd0);
    chk("midrst_addr", dut_if.addr, 16'd0);
    chk("midrst_key", dut_if.key, 8'd0);
    chk("midrst_dv", dut_if.data_valid, 1'b0);
    chk("midrst_err", dut_if.err, 1'b0);
    chk("midrst_code", dut_if.err_code, 2'd0);
    chk("midrst_busy", dut_if.busy, 1'b0);
    chk("midrst_rep", dut_if.repeat_pulse, 1'b0);
    model_data = '0;
    model_code = '0;
    hold(1'b1, 5);
    rst = 1'b0;
    hold(1'b1, 100);

    send_frame(GOOD, -1);
    chk("lit_data_recover", dut_if.data, 32'hA9563412);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
